// File: rtl/bcd2bin_shift_sub3_pkg.sv
// rtl/bcd2bin_shift_sub3_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd2bin_pkg;

  localparam int DEFAULT_DIGITS = 3;
  localparam int DEFAULT_BIN_W  = 10;

  // A digit at or above the threshold picked up a shifted-in 8 and must be corrected by the offset
  localparam logic [3:0] DIGIT_THRESH = 4'd8;
  localparam logic [3:0] DIGIT_OFFSET = 4'd3;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd2bin_shift_sub3_if.sv
// rtl/bcd2bin_shift_sub3_if.sv - request/result bundle between requester and converter
interface bcd2bin_shift_sub3_if
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int BIN_W  = DEFAULT_BIN_W
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [BIN_W-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcd,
    input  binary, busy, done, err
  );

  modport slave (
    input  start, bcd,
    output binary, busy, done, err
  );

endinterface

// File: rtl/bcd2bin_shift_sub3_cell.sv
// rtl/bcd2bin_shift_sub3_cell.sv - per-digit correction: subtract 3 when the digit is 8 or more
module bcd_sub3_cell
  import bcd2bin_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= DIGIT_THRESH) ? (i_d - DIGIT_OFFSET) : i_d;

endmodule

// File: rtl/bcd2bin_shift_sub3.sv
// rtl/bcd2bin_shift_sub3.sv - iterative BCD-to-binary converter using shift right and subtract 3
module bcd2bin_shift_sub3
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS,
  parameter int BIN_W  = DEFAULT_BIN_W
)(
  input  logic                   clk,
  input  logic                   rst_n,
  bcd2bin_shift_sub3_if.slave    bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCD_W-1:0]    r_bcd_work;
  logic [BIN_W-1:0]    r_bin_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_bad;
  logic [BIN_W-1:0]    r_binary;
  logic                r_err;
  logic                r_done;
  logic                w_bad;

  logic [BCD_W+BIN_W-1:0] w_cat;
  logic [BCD_W-1:0]       w_bcd_sh;
  logic [BCD_W-1:0]       w_bcd_fix;
  logic [BIN_W-1:0]       w_bin_sh;

  // One iteration: the combined register moves right by one, low BCD bit falls into the accumulator
  assign w_cat    = {r_bcd_work, r_bin_acc} >> 1;
  assign w_bcd_sh = w_cat[BCD_W+BIN_W-1:BIN_W];
  assign w_bin_sh = w_cat[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_sub3_cell u_cell (
      .i_d (w_bcd_sh[4*g +: 4]),
      .o_d (w_bcd_fix[4*g +: 4])
    );
  end

  // Flag a request carrying any non-decimal digit so it can bypass shifting
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd[4*i +: 4] > DIGIT_MAX) w_bad = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: invalid input skips straight to completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = w_bad ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on request, iterate in SHIFT, publish result on the edge leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_work <= '0;
      r_bin_acc  <= '0;
      r_cnt      <= '0;
      r_bad      <= 1'b0;
      r_binary   <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_bcd_work <= bus.bcd;
            r_bin_acc  <= '0;
            r_cnt      <= '0;
            r_bad      <= w_bad;
          end
        end
        ST_SHIFT: begin
          r_bcd_work <= w_bcd_fix;
          r_bin_acc  <= w_bin_sh;
          r_cnt      <= r_cnt + 1'b1;
        end
        ST_DONE: begin
          // Accumulator is still zero for a rejected request, so binary reads 0 alongside err
          r_binary <= r_bin_acc;
          r_err    <= r_bad;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.binary = r_binary;
  assign bus.err    = r_err;
  assign bus.done   = r_done;
  assign bus.busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bcd2bin_shift_sub3.sv
// tb/tb_bcd2bin_shift_sub3.sv - scoreboard bench for the BCD-to-binary converter
module tb_bcd2bin_shift_sub3;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic             err;
    int               e0;
    int               lat;
    logic [11:0]      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  exp_t sb[$];

  bcd2bin_shift_sub3_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_shift_sub3 #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending request (binary=%0d)", bus.binary);
      end else begin
        e = sb.pop_front();
        chk($sformatf("binary[%h]", e.tag), 32'(bus.binary), 32'(e.bin));
        chk($sformatf("err[%h]", e.tag), 32'(bus.err), 32'(e.err));
        chk($sformatf("latency[%h]", e.tag), 32'(cyc - e.e0), 32'(e.lat));
        chk($sformatf("busy_at_done[%h]", e.tag), 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d done pulses required %0d", n_done, target);
    end
  endtask

  task automatic convert(input logic [11:0] b, input int exp_bin, input logic exp_err, input int lat);
    int prev = n_done;
    @(negedge clk);
    bus.bcd   = b;
    bus.start = 1'b1;
    sb.push_back('{bin: BIN_W'(exp_bin), err: exp_err, e0: cyc + 1, lat: lat, tag: b});
    @(negedge clk);
    bus.start = 1'b0;
    chk($sformatf("busy_after_load[%h]", b), 32'(bus.busy), 32'd1);
    wait_done(prev + 1);
  endtask

  initial begin
    int prev;
    int c;
    logic [11:0] v_bcd;
    bus.start = 1'b0;
    bus.bcd   = '0;

    #1;
    chk("reset_binary", 32'(bus.binary), 32'd0);
    chk("reset_busy",   32'(bus.busy),   32'd0);
    chk("reset_done",   32'(bus.done),   32'd0);
    chk("reset_err",    32'(bus.err),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    convert(12'h255, 255, 1'b0, 11);
    convert(12'h999, 999, 1'b0, 11);
    convert(12'h000, 0,   1'b0, 11);
    convert(12'h004, 4,   1'b0, 11);
    convert(12'h012, 12,  1'b0, 11);
    convert(12'h0C5, 0,   1'b1, 1);
    convert(12'h197, 197, 1'b0, 11);

    // Start held high: second conversion begins 12 cycles after the first
    prev = n_done;
    @(negedge clk);
    c = cyc;
    bus.bcd   = 12'h031;
    bus.start = 1'b1;
    sb.push_back('{bin: BIN_W'(31), err: 1'b0, e0: c + 1,  lat: 11, tag: 12'h031});
    sb.push_back('{bin: BIN_W'(31), err: 1'b0, e0: c + 13, lat: 11, tag: 12'h031});
    repeat (13) @(negedge clk);
    bus.start = 1'b0;
    wait_done(prev + 2);

    // Re-pulsed start and changed bcd while busy must not disturb 0x204
    prev = n_done;
    @(negedge clk);
    bus.bcd   = 12'h204;
    bus.start = 1'b1;
    sb.push_back('{bin: BIN_W'(204), err: 1'b0, e0: cyc + 1, lat: 11, tag: 12'h204});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.bcd   = 12'h111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(prev + 1);
    repeat (15) @(negedge clk);
    chk("single_done_204", 32'(n_done - prev), 32'd1);

    // Reset in the middle of 0x888 aborts with no done pulse
    prev = n_done;
    @(negedge clk);
    bus.bcd   = 12'h888;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_binary", 32'(bus.binary), 32'd0);
    chk("abort_busy",   32'(bus.busy),   32'd0);
    chk("abort_done",   32'(bus.done),   32'd0);
    chk("abort_err",    32'(bus.err),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("no_done_after_abort", 32'(n_done - prev), 32'd0);
    convert(12'h888, 888, 1'b0, 11);

    // Full 0..255 sweep
    for (int v = 0; v < 256; v++) begin
      v_bcd = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      convert(v_bcd, v, 1'b0, 11);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
